rr_mux_arbiter4: RTL and testbench

//   Round-robin arbiter that shares one 4-to-1 mux, DATA_W bits per channel, among 4 requesters.

---
 rtl/arb_pkg.sv | 17 +
 rtl/Mux2Bit4to1.sv | 22 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_mux_arbiter4.sv | 137 +++++++++++++
 tb/tb_rr_mux_arbiter4.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-channel round-robin mux arbiter.
// Also provides the index-to-one-hot helper used for the grant vector.
package arb_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NCH'(1) << idx;
    endfunction

endpackage

// File: rtl/Mux2Bit4to1.sv
// Existing 2-bit wide 4-to-1 multiplexer with enable.
// The output is forced to zero while e is low.
module Mux2Bit4to1 (
    input  logic       e,
    input  logic [1:0] s,
    input  logic [7:0] x,
    output logic [1:0] y
);

    always_comb begin
        y = 2'b00;
        if (e) begin
            case (s)
                2'd0:    y = x[1:0];
                2'd1:    y = x[3:2];
                2'd2:    y = x[5:4];
                default: y = x[7:6];
            endcase
        end
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping.
// The any output flags that at least one request is present.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;
    logic             found;

    assign any = |req;

    // The candidate index wraps naturally because it is only SEL_W bits wide.
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NCH; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters with a valid/ready output.
// Define ARB_STATS_EN to add per-channel saturating grant counters (grant_cnt, stats_clr).
module rr_mux_arbiter4
    import arb_pkg::*;
#(
    parameter int DATA_W = 2
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*DATA_W-1:0] x,
    input  logic                  y_ready,
    output logic [DATA_W-1:0]     y,
    output logic                  y_valid,
    output logic [SEL_W-1:0]      sel,
    output logic [NCH-1:0]        grant,
    output logic [NCH-1:0]        ack,
`ifdef ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [NCH*CNT_W-1:0]  grant_cnt,
`endif
    output logic                  busy
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d, sel_d;
    logic [NCH-1:0]   grant_d;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             xfer;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel     <= '0;
            grant   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel     <= sel_d;
            grant   <= grant_d;
        end
    end

    // A reset sampled mid-SEND must not complete the in-flight transfer.
    assign busy    = (state_q == SEND);
    assign y_valid = busy && req[sel] && !reset;
    assign xfer    = y_valid && y_ready;
    assign ack     = xfer ? grant : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel;
        grant_d = grant;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    ptr_d   = sel + SEL_W'(1);
                    grant_d = '0;
                    state_d = IDLE;
                end else if (!req[sel]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    generate
        if (DATA_W == 2) begin : g_mux2
            Mux2Bit4to1 u_mux (
                .e (y_valid),
                .s (sel),
                .x (x),
                .y (y)
            );
        end else begin : g_mux_inline
            always_comb begin
                y = '0;
                if (y_valid) begin
                    y = x[sel*DATA_W +: DATA_W];
                end
            end
        end
    endgenerate

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NCH];

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset || stats_clr) begin
                cnt_q[i] <= '0;
            end else if (ack[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(grant));
            assert (!busy || (grant == onehot(sel)));
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Self-checking bench for rr_mux_arbiter4: directed scenarios plus randomized traffic
// compared every cycle against a behavioural round-robin model (ARB_STATS_EN optional).
module tb_rr_mux_arbiter4;

    localparam int DATA_W  = 2;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] x;
    logic       y_ready;
    logic [1:0] y;
    logic       y_valid;
    logic [1:0] sel;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       busy;
    logic       stats_clr;
`ifdef ARB_STATS_EN
    logic [4*CNT_W-1:0] grant_cnt;
`endif

    rr_mux_arbiter4 #(
        .DATA_W (DATA_W)
`ifdef ARB_STATS_EN
        , .CNT_W (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .x         (x),
        .y_ready   (y_ready),
        .y         (y),
        .y_valid   (y_valid),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack),
`ifdef ARB_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int testsRun  = 0;
    int failCount = 0;

    // Behavioural model: whether a grant is outstanding, who holds it, and the rotation start.
    bit mSend = 1'b0;
    int mPtr  = 0;
    int mSel  = 0;
    int mCnt [4] = '{0, 0, 0, 0};

    logic [1:0] obsY, obsSel;
    logic       obsValid, obsBusy;
    logic [3:0] obsGrant, obsAck;
    logic [7:0] obsCnt;

    int ackCh[$];
    int ackCyc[$];
    int expSeq [5] = '{0, 1, 2, 3, 0};
    logic [3:0] dropMask;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int ackIdx(input logic [3:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, compare outputs with the model, then advance both by one edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] xv, input logic yr,
                                 input logic rst, input logic clr);
        bit expValid;
        int expY, expAck, expGrant, packed_cnt;
        req       = r;
        x         = xv;
        y_ready   = yr;
        reset     = rst;
        stats_clr = clr;
        #1;
        expValid = mSend && r[mSel] && !rst;
        expY     = expValid ? ((int'(xv) >> (2 * mSel)) & 3) : 0;
        expAck   = (expValid && yr) ? (1 << mSel) : 0;
        expGrant = mSend ? (1 << mSel) : 0;
        checkOutput("y", 32'(y), expY);
        checkOutput("y_valid", 32'(y_valid), 32'(expValid));
        checkOutput("sel", 32'(sel), mSel);
        checkOutput("grant", 32'(grant), expGrant);
        checkOutput("ack", 32'(ack), expAck);
        checkOutput("busy", 32'(busy), 32'(mSend));
        obsY = y; obsValid = y_valid; obsSel = sel;
        obsGrant = grant; obsAck = ack; obsBusy = busy;
        obsCnt = '0;
`ifdef ARB_STATS_EN
        packed_cnt = 0;
        for (int i = 0; i < 4; i++) packed_cnt += mCnt[i] << (CNT_W * i);
        checkOutput("grant_cnt", 32'(grant_cnt), packed_cnt);
        obsCnt = grant_cnt;
`else
        packed_cnt = 0;
`endif
        @(posedge clk);
        if (rst) begin
            mSend = 1'b0;
            mPtr  = 0;
            mSel  = 0;
        end else if (!mSend) begin
            if (r != 4'b0) begin
                for (int k = 3; k >= 0; k--) begin
                    if (r[(mPtr + k) % 4]) mSel = (mPtr + k) % 4;
                end
                mSend = 1'b1;
            end
        end else if (expValid && yr) begin
            if (mCnt[mSel] < CNT_MAX) mCnt[mSel]++;
            mPtr  = (mSel + 1) % 4;
            mSend = 1'b0;
        end else if (!r[mSel]) begin
            mSend = 1'b0;
        end
        if (rst || clr) begin
            for (int i = 0; i < 4; i++) mCnt[i] = 0;
        end
        #1;
    endtask

    initial begin
        logic [7:0] xv;
        logic [3:0] rr;
        reset = 1'b1; req = 4'hF; x = '0; y_ready = 1'b1; stats_clr = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset with all requests high");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'hF, 8'($urandom), 1'b1, 1'b1, 1'b0);
            checkOutput("t1 busy", 32'(obsBusy), 0);
            checkOutput("t1 grant", 32'(obsGrant), 0);
        end

        $display("[TB] single request on ch2");
        applyStimulus(4'b0100, 8'h20, 1'b1, 1'b0, 1'b0);
        checkOutput("t2 idle busy", 32'(obsBusy), 0);
        applyStimulus(4'b0100, 8'h20, 1'b1, 1'b0, 1'b0);
        checkOutput("t2 sel", 32'(obsSel), 2);
        checkOutput("t2 grant", 32'(obsGrant), 32'h4);
        checkOutput("t2 y", 32'(obsY), 2);
        checkOutput("t2 y_valid", 32'(obsValid), 1);
        checkOutput("t2 ack", 32'(obsAck), 32'h4);
        applyStimulus(4'b0000, 8'h20, 1'b1, 1'b0, 1'b0);
        checkOutput("t2 back to idle", 32'(obsBusy), 0);

        $display("[TB] backpressure on ch1");
        xv = 8'($urandom);
        applyStimulus(4'b0010, xv, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, xv, 1'b0, 1'b0, 1'b0);
            checkOutput("t4 hold valid", 32'(obsValid), 1);
            checkOutput("t4 hold sel", 32'(obsSel), 1);
            checkOutput("t4 hold ack", 32'(obsAck), 0);
        end
        applyStimulus(4'b0010, xv, 1'b1, 1'b0, 1'b0);
        checkOutput("t4 release ack", 32'(obsAck), 32'h2);
        applyStimulus(4'b0000, xv, 1'b1, 1'b0, 1'b0);

        $display("[TB] withdrawal of ch3");
        applyStimulus(4'b1000, xv, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1000, xv, 1'b0, 1'b0, 1'b0);
        checkOutput("t5 granted ch3", 32'(obsSel), 3);
        applyStimulus(4'b0001, xv, 1'b1, 1'b0, 1'b0);
        checkOutput("t5 withdraw valid", 32'(obsValid), 0);
        checkOutput("t5 withdraw ack", 32'(obsAck), 0);
        applyStimulus(4'b0001, xv, 1'b1, 1'b0, 1'b0);
        checkOutput("t5 idle after withdraw", 32'(obsBusy), 0);
        applyStimulus(4'b0001, xv, 1'b1, 1'b0, 1'b0);
        checkOutput("t5 next sel", 32'(obsSel), 0);
        checkOutput("t5 next ack", 32'(obsAck), 32'h1);
        applyStimulus(4'b0000, xv, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset during SEND");
        applyStimulus(4'b0100, xv, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100, xv, 1'b0, 1'b0, 1'b0);
        checkOutput("t7 in send", 32'(obsBusy), 1);
        applyStimulus(4'b0100, xv, 1'b1, 1'b1, 1'b0);
        checkOutput("t7 reset ack", 32'(obsAck), 0);
        applyStimulus(4'b0000, xv, 1'b1, 1'b0, 1'b0);
        checkOutput("t7 idle after reset", 32'(obsBusy), 0);

        $display("[TB] rotation with all channels requesting");
        applyStimulus(4'b0000, xv, 1'b1, 1'b1, 1'b0);
        dropMask = 4'b0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'hF & ~dropMask, 8'($urandom), 1'b1, 1'b0, 1'b0);
            if (obsAck != 4'b0) begin
                ackCh.push_back(ackIdx(obsAck));
                ackCyc.push_back(c);
            end
            dropMask = obsAck;
        end
        checkOutput("t3 ack count", 32'(ackCh.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ackCh.size()) checkOutput("t3 ack channel", 32'(ackCh[i]), 32'(expSeq[i]));
            if (i > 0 && i < ackCyc.size()) checkOutput("t3 ack spacing", 32'(ackCyc[i] - ackCyc[i-1]), 2);
        end

`ifdef ARB_STATS_EN
        $display("[TB] grant counter saturation and clear");
        applyStimulus(4'b0000, xv, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0100, xv, 1'b1, 1'b0, 1'b0);
            applyStimulus(4'b0100, xv, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(4'b0000, xv, 1'b1, 1'b0, 1'b0);
        checkOutput("t6 ch2 saturated", 32'(obsCnt[5:4]), 3);
        applyStimulus(4'b0000, xv, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0000, xv, 1'b1, 1'b0, 1'b0);
        checkOutput("t6 cleared", 32'(obsCnt), 0);
`endif

        $display("[TB] randomized traffic");
        rr = 4'($urandom_range(0, 15));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 2) rr = 4'($urandom_range(0, 15));
            applyStimulus(rr, 8'($urandom), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0));
            if (obsAck != 4'b0) rr = rr & ~obsAck;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
